// File: rtl/aes_subbytes_serial.sv
// aes_subbytes_serial
//   Iterative AES SubBytes (+ optional ShiftRows) stage. A 128-bit state is
//   accepted over a valid/ready handshake. BPC bytes are substituted per cycle
//   in place in state_q over N = 16/BPC cycles. The result is then held on
//   dout until the downstream stage takes it.
//
//   Parameters
//     BPC        bytes substituted per cycle (1,2,4,8,16) = number of sBox_8 lanes
//     SHIFT_ROWS 1: dout is ShiftRows(state_q); 0: dout = state_q
//   Ports
//     clk, rst_n           clock (rising edge), async active-low reset
//     in_valid/in_ready    input handshake, din carries the state
//     out_valid/out_ready  output handshake, dout carries the result
//     busy                 high while substituting or holding a result
//   Byte i of a state lives at [127-8i -: 8]; column-major (row=i%4, col=i/4).

// sBox_8: combinational AES S-box, computed as GF(2^8) inverse + affine map.
module sBox_8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // inverse = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_subbytes_serial #(
  parameter int BPC        = 1,
  parameter bit SHIFT_ROWS = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);
  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
      $error("aes_subbytes_serial: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SUB, DONE} st_t;
  st_t st, st_nx;

  logic [127:0]          state_q, state_d;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic [15:0][7:0]      sbyte;
  logic [BPC-1:0][7:0]   sb_in, sb_out;

  assign last = (int'(cnt) == N - 1);

  // byte view of state_q, index = AES byte number
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign sbyte[gi] = state_q[127-8*gi -: 8];
    end
  endgenerate

  // lane j substitutes byte cnt*BPC + j
  always_comb begin
    for (int j = 0; j < BPC; j++) sb_in[j] = sbyte[4'(int'(cnt) * BPC + j)];
  end

  generate
    for (gi = 0; gi < BPC; gi++) begin : g_lane
      sBox_8 u_sbox (.a(sb_in[gi]), .y(sb_out[gi]));
    end
  endgenerate

  // write substituted bytes back into their slots, others hold
  always_comb begin
    state_d = state_q;
    for (int k = 0; k < 16; k++)
      if (int'(cnt) == k / BPC) state_d[127-8*k -: 8] = sb_out[k % BPC];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;

  // FSM: next state
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (in_valid)  st_nx = SUB;
      SUB:     if (last)      st_nx = DONE;
      DONE:    if (out_ready) st_nx = IDLE;
      default:                st_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
    busy      = (st != IDLE);
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      cnt     <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          state_q <= din;
          cnt     <= '0;
        end
        SUB: begin
          state_q <= state_d;
          cnt     <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // output byte (r+4c) takes state byte (r + 4*((c+r)%4)) when ShiftRows is on
  generate
    if (SHIFT_ROWS) begin : g_sr
      genvar r, c;
      for (r = 0; r < 4; r++) begin : g_row
        for (c = 0; c < 4; c++) begin : g_col
          assign dout[127-8*(r+4*c) -: 8] = sbyte[r + 4*((c + r) % 4)];
        end
      end
    end else begin : g_nosr
      assign dout = state_q;
    end
  endgenerate
endmodule
